// File: rtl/jogo_memoria_param.sv
// Sequence-memory game core: reads the expected play from an external memory and judges each press.
// Optional playback phase is compiled in with `define JOGO_MOSTRA_SEQUENCIA_EN.
module jogo_memoria_param #(
    parameter int N_BOTOES       = 4,
    parameter int N_RODADAS      = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int T_MOSTRA       = 1000,
    parameter int AW             = $clog2(N_RODADAS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic [N_BOTOES-1:0] mem_dado,
    output logic [AW-1:0]       mem_endereco,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic [AW-1:0]       db_rodada,
    output logic [3:0]          db_estado
);

    localparam int T_MAX = (TIMEOUT_CICLOS > T_MOSTRA) ? TIMEOUT_CICLOS : T_MOSTRA;
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL      = 4'h0,
        PREPARA      = 4'h1,
`ifdef JOGO_MOSTRA_SEQUENCIA_EN
        MOSTRA       = 4'h2,
        MOSTRA_PAUSA = 4'h3,
`endif
        ESPERA       = 4'h4,
        REGISTRA     = 4'h5,
        COMPARA      = 4'h6,
        PROXIMA      = 4'h7,
        FIM_GANHOU   = 4'h8,
        FIM_PERDEU   = 4'h9,
        FIM_TIMEOUT  = 4'hA
    } estado_t;

`ifdef JOGO_MOSTRA_SEQUENCIA_EN
    localparam estado_t INICIO_RODADA = MOSTRA;
`else
    localparam estado_t INICIO_RODADA = ESPERA;
`endif

    estado_t             estado;
    logic [AW-1:0]       rodada;
    logic [AW-1:0]       endereco;
    logic [CW-1:0]       contador;
    logic [N_BOTOES-1:0] jogada;
    logic [N_BOTOES-1:0] botoes_ant;
    logic                evento;

    // A play is a 0 -> nonzero transition, so a button held over from the last play is ignored.
    assign evento = (botoes != '0) && (botoes_ant == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= INICIAL;
            rodada     <= '0;
            endereco   <= '0;
            contador   <= '0;
            jogada     <= '0;
            botoes_ant <= '0;
            pronto     <= 1'b0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            botoes_ant <= botoes;
            case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        estado   <= PREPARA;
                        rodada   <= '0;
                        endereco <= '0;
                        contador <= '0;
                    end
                end
                PREPARA: begin
                    rodada   <= '0;
                    endereco <= '0;
                    contador <= '0;
                    estado   <= INICIO_RODADA;
                end
`ifdef JOGO_MOSTRA_SEQUENCIA_EN
                MOSTRA: begin
                    if (contador == CW'(T_MOSTRA - 1)) begin
                        contador <= '0;
                        estado   <= MOSTRA_PAUSA;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                MOSTRA_PAUSA: begin
                    if (contador == CW'(T_MOSTRA - 1)) begin
                        contador <= '0;
                        if (endereco == rodada) begin
                            endereco <= '0;
                            estado   <= ESPERA;
                        end else begin
                            endereco <= endereco + 1'b1;
                            estado   <= MOSTRA;
                        end
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
`endif
                ESPERA: begin
                    contador <= contador + 1'b1;
                    // A press on the final allowed cycle still counts.
                    if (evento) begin
                        estado <= REGISTRA;
                    end else if (contador == CW'(TIMEOUT_CICLOS - 1)) begin
                        estado  <= FIM_TIMEOUT;
                        pronto  <= 1'b1;
                        perdeu  <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                REGISTRA: begin
                    jogada <= botoes;
                    estado <= COMPARA;
                end
                COMPARA: begin
                    if (jogada != mem_dado) begin
                        estado <= FIM_PERDEU;
                        pronto <= 1'b1;
                        perdeu <= 1'b1;
                    end else if (endereco != rodada) begin
                        endereco <= endereco + 1'b1;
                        contador <= '0;
                        estado   <= ESPERA;
                    end else if (rodada == AW'(N_RODADAS - 1)) begin
                        estado <= FIM_GANHOU;
                        pronto <= 1'b1;
                        ganhou <= 1'b1;
                    end else begin
                        estado <= PROXIMA;
                    end
                end
                PROXIMA: begin
                    rodada   <= rodada + 1'b1;
                    endereco <= '0;
                    contador <= '0;
                    estado   <= INICIO_RODADA;
                end
                FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                    if (iniciar) begin
                        estado   <= PREPARA;
                        rodada   <= '0;
                        endereco <= '0;
                        contador <= '0;
                        pronto   <= 1'b0;
                        ganhou   <= 1'b0;
                        perdeu   <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    always_comb begin
        leds = '0;
        case (estado)
            ESPERA, REGISTRA: leds = botoes;
`ifdef JOGO_MOSTRA_SEQUENCIA_EN
            MOSTRA:           leds = mem_dado;
`endif
            default:          leds = '0;
        endcase
    end

    assign mem_endereco = endereco;
    assign db_rodada    = rodada;
    assign db_estado    = estado;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Scoreboard bench for jogo_memoria_param (default build): verdicts are queued at each press
// and compared when the FSM reaches its decision.
module tb_jogo_memoria_param;

    localparam int NB = 4;
    localparam int NR = 4;
    localparam int TO = 20;
    localparam int TM = 3;
    localparam int AW = $clog2(NR);

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic [NB-1:0] botoes;
    logic [NB-1:0] mem_dado;
    logic [AW-1:0] mem_endereco;
    logic [NB-1:0] leds;
    logic          pronto, ganhou, perdeu, timeout;
    logic [AW-1:0] db_rodada;
    logic [3:0]    db_estado;

    logic [NB-1:0] mem [NR] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    int checks   = 0;
    int failures = 0;
    int fila[$];
    int rod_m, end_m;

    always #5 clock = ~clock;

    assign mem_dado = mem[mem_endereco];

    jogo_memoria_param #(
        .N_BOTOES      (NB),
        .N_RODADAS     (NR),
        .TIMEOUT_CICLOS(TO),
        .T_MOSTRA      (TM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .botoes      (botoes),
        .mem_dado    (mem_dado),
        .mem_endereco(mem_endereco),
        .leds        (leds),
        .pronto      (pronto),
        .ganhou      (ganhou),
        .perdeu      (perdeu),
        .timeout     (timeout),
        .db_rodada   (db_rodada),
        .db_estado   (db_estado)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference game: returns the state code expected three cycles after a press.
    task automatic modelo(input logic [NB-1:0] v, output int esp);
        if (v != mem[end_m]) begin
            esp = 9;
        end else if (end_m != rod_m) begin
            end_m++;
            esp = 4;
        end else if (rod_m == NR - 1) begin
            esp = 8;
        end else begin
            rod_m++;
            end_m = 0;
            esp = 7;
        end
    endtask

    task automatic inicia();
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        check_val("prepara_estado", db_estado, 1);
        check_val("prepara_rodada", db_rodada, 0);
        check_val("prepara_pronto", pronto, 0);
        tick(1);
        check_val("espera_inicial", db_estado, 4);
        rod_m = 0;
        end_m = 0;
    endtask

    task automatic joga(input logic [NB-1:0] v, input int segura);
        int esp;
        int veredito;
        check_val("endereco", mem_endereco, end_m);
        check_val("rodada", db_rodada, rod_m);
        modelo(v, esp);
        fila.push_back(esp);
        botoes = v;
        tick(1);
        check_val("registra", db_estado, 5);
        check_val("leds_espelho", leds, v);
        tick(1);
        check_val("compara", db_estado, 6);
        tick(1);
        check_val("fila_tamanho", fila.size(), 1);
        veredito = (fila.size() > 0) ? fila.pop_front() : -1;
        check_val("veredito", db_estado, veredito);
        tick(segura);
        if (veredito == 4 || veredito == 7)
            check_val("botao_segurado", db_estado, 4);
        botoes = '0;
        tick(5);
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        botoes  = '0;
        rod_m   = 0;
        end_m   = 0;
        tick(2);
        check_val("rst_leds", leds, 0);
        check_val("rst_pronto", pronto, 0);
        check_val("rst_ganhou", ganhou, 0);
        check_val("rst_perdeu", perdeu, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_endereco", mem_endereco, 0);
        check_val("rst_rodada", db_rodada, 0);
        check_val("rst_estado", db_estado, 0);
        reset = 1'b0;
        tick(2);
        check_val("ocioso", db_estado, 0);

        // Full win
        inicia();
        for (int r = 0; r < NR; r++)
            for (int i = 0; i <= r; i++)
                joga(mem[i], 2);
        check_val("win_ganhou", ganhou, 1);
        check_val("win_pronto", pronto, 1);
        check_val("win_perdeu", perdeu, 0);
        check_val("win_estado", db_estado, 8);
        check_val("win_rodada", db_rodada, 3);
        check_val("win_leds", leds, 0);

        // Wrong play in the second round
        inicia();
        check_val("restart_ganhou", ganhou, 0);
        joga(4'b0001, 2);
        joga(4'b0001, 2);
        joga(4'b0100, 2);
        check_val("erro_perdeu", perdeu, 1);
        check_val("erro_timeout", timeout, 0);
        check_val("erro_estado", db_estado, 9);

        // Timeout after restart from a loss
        inicia();
        check_val("restart_perdeu", perdeu, 0);
        tick(TO - 1);
        check_val("pre_timeout", db_estado, 4);
        tick(1);
        check_val("to_estado", db_estado, 4'hA);
        check_val("to_timeout", timeout, 1);
        check_val("to_perdeu", perdeu, 1);
        check_val("to_pronto", pronto, 1);
        check_val("to_ganhou", ganhou, 0);

        // Press on the last allowed cycle, then reset in the third round
        inicia();
        tick(TO - 1);
        joga(4'b0001, 2);
        check_val("ultimo_ciclo_timeout", timeout, 0);
        joga(4'b0001, 2);
        joga(4'b0010, 2);
        check_val("rodada_3", db_rodada, 2);
        check_val("rodada_3_estado", db_estado, 4);
        botoes = 4'b0001;
        #1;
        reset = 1'b1;
        #1;
        check_val("rst_async_estado", db_estado, 0);
        check_val("rst_async_rodada", db_rodada, 0);
        check_val("rst_async_endereco", mem_endereco, 0);
        check_val("rst_async_leds", leds, 0);
        check_val("rst_async_pronto", pronto, 0);
        tick(2);
        botoes = '0;
        reset  = 1'b0;
        tick(1);

        // Held button and multi-button press
        inicia();
        joga(4'b0001, 5);
        check_val("segurado_rodada", db_rodada, 1);
        joga(4'b0011, 2);
        check_val("multi_perdeu", perdeu, 1);
        check_val("multi_estado", db_estado, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
